fact_sequencer: RTL and testbench

Bus-master controller that batches factorial jobs through the shared 64-bit system bus. When started, it performs these steps for each job in turn:
- read an operand from RAM;
- program and start FactoCore;
- wait for FactoCore's interrupt;
- copy the 128-bit result back to RAM;
- clear FactoCore.

It sits on the bus master port (m_req/m_grant handshake) alongside or in place of the external host, so jobs run without host intervention.

---
 rtl/fact_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_fact_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_sequencer.sv
// Bus-master sequencer that runs a batch of factorial jobs through FactoCore:
// fetch operand from RAM, start the core, await its interrupt, copy the result back.
module fact_sequencer #(
  parameter logic [15:0] FC_BASE = 16'h7000,
  parameter int          TIMEOUT = 4096,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  output logic             m_req,
  input  logic             m_grant,
  output logic             m_wr,
  output logic [15:0]      m_addr,
  output logic [63:0]      m_dout,
  input  logic [63:0]      m_din,
  input  logic             interrupt,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] job_idx
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [15:0] A_OPSTART = FC_BASE + 16'h00;
  localparam logic [15:0] A_OPCLEAR = FC_BASE + 16'h08;
  localparam logic [15:0] A_INTEN   = FC_BASE + 16'h18;
  localparam logic [15:0] A_OPERAND = FC_BASE + 16'h20;
  localparam logic [15:0] A_RESH    = FC_BASE + 16'h28;
  localparam logic [15:0] A_RESL    = FC_BASE + 16'h30;

  typedef enum logic [3:0] {
    S_IDLE, S_EN_INT, S_RD_OP_A, S_RD_OP_D, S_WR_OPND, S_WR_START, S_WAIT_INT,
    S_RD_RH_A, S_RD_RH_D, S_RD_RL_A, S_RD_RL_D, S_WR_RH, S_WR_RL, S_WR_CLR, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_job, w_job_nxt;
  logic [CNT_W:0]     w_job_inc;
  logic [TCNT_W-1:0]  r_tcnt, w_tcnt_nxt;
  logic               r_err, w_err_nxt;
  logic               r_busy, r_done;
  logic               r_req, r_wr, w_req, w_wr;
  logic [15:0]        r_addr, w_addr, w_op_addr, w_res_addr;
  logic [63:0]        r_dout, w_dout;
  logic               w_latch;
  logic [15:0]        r_src, r_dst;
  logic [CNT_W-1:0]   r_cnt;
  logic [63:0]        r_rh, r_rl;

  assign w_job_inc = {1'b0, r_job} + (CNT_W+1)'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_job_nxt   = r_job;
    w_tcnt_nxt  = r_tcnt;
    w_err_nxt   = r_err;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_latch     = 1'b1;
        w_job_nxt   = '0;
        w_err_nxt   = 1'b0;
        w_state_nxt = (count == '0) ? S_DONE : S_EN_INT;
      end
      S_EN_INT:   if (m_grant) w_state_nxt = S_RD_OP_A;
      S_RD_OP_A:  if (m_grant) w_state_nxt = S_RD_OP_D;
      S_RD_OP_D:  if (m_grant) w_state_nxt = S_WR_OPND;
      S_WR_OPND:  if (m_grant) w_state_nxt = S_WR_START;
      S_WR_START: if (m_grant) begin
        w_state_nxt = S_WAIT_INT;
        w_tcnt_nxt  = '0;
      end
      // Interrupt takes priority over a timeout landing in the same cycle.
      S_WAIT_INT: begin
        if (interrupt) begin
          w_state_nxt = S_RD_RH_A;
        end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_WR_CLR;
          w_err_nxt   = 1'b1;
        end else begin
          w_tcnt_nxt  = r_tcnt + TCNT_W'(1);
        end
      end
      S_RD_RH_A:  if (m_grant) w_state_nxt = S_RD_RH_D;
      S_RD_RH_D:  if (m_grant) w_state_nxt = S_RD_RL_A;
      S_RD_RL_A:  if (m_grant) w_state_nxt = S_RD_RL_D;
      S_RD_RL_D:  if (m_grant) w_state_nxt = S_WR_RH;
      S_WR_RH:    if (m_grant) w_state_nxt = S_WR_RL;
      S_WR_RL:    if (m_grant) w_state_nxt = S_WR_CLR;
      S_WR_CLR: if (m_grant) begin
        if (w_job_inc < {1'b0, r_cnt}) begin
          w_state_nxt = S_RD_OP_A;
          w_job_nxt   = w_job_inc[CNT_W-1:0];
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are loaded only on a state change, so a stalled access holds them.
  always_comb begin
    w_req      = r_req;
    w_wr       = r_wr;
    w_addr     = r_addr;
    w_dout     = r_dout;
    w_op_addr  = r_src + (16'(w_job_nxt) << 3);
    w_res_addr = r_dst + (16'(w_job_nxt) << 4);
    if (w_state_nxt != r_state) begin
      w_req  = 1'b1;
      w_wr   = 1'b0;
      w_addr = 16'h0;
      w_dout = 64'h0;
      case (w_state_nxt)
        S_EN_INT:              begin w_wr = 1'b1; w_addr = A_INTEN;   w_dout = 64'd1; end
        S_RD_OP_A, S_RD_OP_D:  w_addr = w_op_addr;
        S_WR_OPND:             begin w_wr = 1'b1; w_addr = A_OPERAND; w_dout = m_din; end
        S_WR_START:            begin w_wr = 1'b1; w_addr = A_OPSTART; w_dout = 64'd1; end
        S_RD_RH_A, S_RD_RH_D:  w_addr = A_RESH;
        S_RD_RL_A, S_RD_RL_D:  w_addr = A_RESL;
        S_WR_RH:               begin w_wr = 1'b1; w_addr = w_res_addr;          w_dout = r_rh; end
        S_WR_RL:               begin w_wr = 1'b1; w_addr = w_res_addr + 16'h8;  w_dout = r_rl; end
        S_WR_CLR:              begin w_wr = 1'b1; w_addr = A_OPCLEAR; w_dout = 64'd1; end
        default:               w_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_job   <= '0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= 16'h0;
      r_dout  <= 64'h0;
    end else begin
      r_state <= w_state_nxt;
      r_job   <= w_job_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done  <= (w_state_nxt == S_DONE);
      r_req   <= w_req;
      r_wr    <= w_wr;
      r_addr  <= w_addr;
      r_dout  <= w_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_src <= src_addr;
      r_dst <= dst_addr;
      r_cnt <= count;
    end
    if (r_state == S_RD_RH_D && m_grant) r_rh <= m_din;
    if (r_state == S_RD_RL_D && m_grant) r_rl <= m_din;
  end

  assign m_req   = r_req;
  assign m_wr    = r_wr;
  assign m_addr  = r_addr;
  assign m_dout  = r_dout;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_err;
  assign job_idx = r_job;

endmodule

// File: tb/tb_fact_sequencer.sv
// Bench for fact_sequencer: RAM + FactoCore bus model, expected bus cycles queued
// by the stimulus and popped by an independent monitor.
module tb_fact_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, m_grant, interrupt;
  logic [15:0] src_addr, dst_addr, m_addr;
  logic [7:0]  count, job_idx;
  logic        m_req, m_wr, busy, done, error;
  logic [63:0] m_dout, m_din;

  always #5 clk = ~clk;

  fact_sequencer #(.FC_BASE(16'h7000), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr), .m_addr(m_addr),
    .m_dout(m_dout), .m_din(m_din), .interrupt(interrupt), .busy(busy), .done(done),
    .error(error), .job_idx(job_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // RAM and FactoCore model
  logic [63:0]  ram   [0:8191];
  bit           ram_v [0:8191];
  logic [63:0]  fc_opnd;
  logic [127:0] fc_res;
  logic         fc_ie = 1'b0;
  int           fc_cd = 0;
  bit           fc_auto = 1'b1;

  function automatic logic [63:0] ram_init(input logic [15:0] a);
    case (a)
      16'h0000: return 64'd5;
      16'h0200: return 64'd0;
      16'h0208: return 64'd1;
      16'h0210: return 64'd20;
      16'h0400: return 64'd3;
      16'h0600: return 64'd7;
      default:  return {48'h0000C0DE0000, a};
    endcase
  endfunction

  function automatic logic [63:0] ram_peek(input logic [15:0] a);
    return ram_v[a[15:3]] ? ram[a[15:3]] : ram_init(a);
  endfunction

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r = 128'd1;
    for (int i = 2; i <= 40 && i <= int'(n); i++) r = r * 128'(i);
    return r;
  endfunction

  always_comb begin
    if (m_addr == 16'h7028)          m_din = fc_res[127:64];
    else if (m_addr == 16'h7030)     m_din = fc_res[63:0];
    else if (ram_v[m_addr[15:3]])    m_din = ram[m_addr[15:3]];
    else                             m_din = ram_init(m_addr);
  end

  always @(posedge clk) begin
    if (reset) begin
      interrupt <= 1'b0;
      fc_cd     <= 0;
    end else begin
      if (fc_cd > 1) fc_cd <= fc_cd - 1;
      else if (fc_cd == 1) begin
        fc_cd <= 0;
        if (fc_auto && fc_ie) interrupt <= 1'b1;
      end
      if (m_req && m_grant && m_wr) begin
        case (m_addr)
          16'h7018: fc_ie   <= m_dout[0];
          16'h7020: fc_opnd <= m_dout;
          16'h7000: begin fc_res <= fact(fc_opnd); fc_cd <= 6; end
          16'h7008: begin interrupt <= 1'b0; fc_cd <= 0; end
          default:  begin ram[m_addr[15:3]] <= m_dout; ram_v[m_addr[15:3]] <= 1'b1; end
        endcase
      end
    end
  end

  // Scoreboard
  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  job;
  } bus_t;
  bus_t q[$];

  task automatic push(input logic wr, input logic [15:0] a, input logic [63:0] d, input logic [7:0] j);
    bus_t e;
    e.wr = wr; e.addr = a; e.data = d; e.job = j;
    q.push_back(e);
  endtask

  task automatic push_job(input logic [15:0] oa, input logic [15:0] ra, input logic [7:0] j,
                          input logic [63:0] op, input logic [63:0] rh, input logic [63:0] rl,
                          input bit tmo);
    push(1'b0, oa, 64'h0, j);
    push(1'b0, oa, 64'h0, j);
    push(1'b1, 16'h7020, op, j);
    push(1'b1, 16'h7000, 64'd1, j);
    if (!tmo) begin
      push(1'b0, 16'h7028, 64'h0, j);
      push(1'b0, 16'h7028, 64'h0, j);
      push(1'b0, 16'h7030, 64'h0, j);
      push(1'b0, 16'h7030, 64'h0, j);
      push(1'b1, ra, rh, j);
      push(1'b1, ra + 16'h8, rl, j);
    end
    push(1'b1, 16'h7008, 64'd1, j);
  endtask

  always @(negedge clk) begin
    if (!reset && m_req && m_grant) begin
      if (q.size() == 0) begin
        chk("bus_unexpected", 128'({m_wr, m_addr, m_dout}), 128'(0));
      end else begin
        bus_t e, a;
        e = q.pop_front();
        a.wr = m_wr; a.addr = m_addr; a.data = m_wr ? m_dout : 64'h0; a.job = job_idx;
        chk("bus", 128'(a), 128'(e));
      end
    end
  end

  task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [7:0] c);
    @(negedge clk);
    src_addr = s; dst_addr = d; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = 16'hFFF8; dst_addr = 16'hFFF0; count = 8'hFF;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (done !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    chk({nm, "_done"}, 128'({done, busy}), 128'({1'b1, 1'b0}));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 128'(done), 128'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; m_grant = 1'b1;
    src_addr = 16'h0; dst_addr = 16'h0; count = 8'h0;
    repeat (2) @(negedge clk);
    chk("reset_state", 128'({m_req, m_wr, m_addr, m_dout, busy, done, error, job_idx}), 128'(0));
    reset = 1'b0;

    // Single job 5! = 120
    push(1'b1, 16'h7018, 64'd1, 8'd0);
    push_job(16'h0000, 16'h0100, 8'd0, 64'd5, 64'd0, 64'd120, 1'b0);
    do_start(16'h0000, 16'h0100, 8'd1);
    chk("t1_busy", 128'(busy), 128'(1));
    wait_done("t1");
    chk("t1_err", 128'(error), 128'(0));
    chk("t1_ram", 128'({ram_peek(16'h0100), ram_peek(16'h0108)}), {64'd0, 64'd120});

    // Three jobs: 0!, 1!, 20!
    push(1'b1, 16'h7018, 64'd1, 8'd0);
    push_job(16'h0200, 16'h0300, 8'd0, 64'd0,  64'd0, 64'd1, 1'b0);
    push_job(16'h0208, 16'h0310, 8'd1, 64'd1,  64'd0, 64'd1, 1'b0);
    push_job(16'h0210, 16'h0320, 8'd2, 64'd20, 64'd0, 64'h21C3677C82B40000, 1'b0);
    do_start(16'h0200, 16'h0300, 8'd3);
    wait_done("t2");
    chk("t2_ram_last", 128'({ram_peek(16'h0320), ram_peek(16'h0328)}), {64'd0, 64'h21C3677C82B40000});
    chk("t2_job_idx_end", 128'(job_idx), 128'(2));

    // Grant withheld during the operand read address phase
    push(1'b1, 16'h7018, 64'd1, 8'd0);
    push_job(16'h0400, 16'h0500, 8'd0, 64'd3, 64'd0, 64'd6, 1'b0);
    do_start(16'h0400, 16'h0500, 8'd1);
    chk("t3_en_int", 128'({m_req, m_wr, m_addr}), 128'({1'b1, 1'b1, 16'h7018}));
    @(posedge clk); #1 m_grant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_stall", 128'({m_req, m_wr, m_addr, job_idx}), 128'({1'b1, 1'b0, 16'h0400, 8'd0}));
    end
    @(posedge clk); #1 m_grant = 1'b1;
    wait_done("t3");
    chk("t3_ram", 128'(ram_peek(16'h0508)), 128'(6));

    // Interrupt never arrives: timeout after 16 wait cycles
    fc_auto = 1'b0;
    push(1'b1, 16'h7018, 64'd1, 8'd0);
    push_job(16'h0600, 16'h0700, 8'd0, 64'd7, 64'd0, 64'd0, 1'b1);
    do_start(16'h0600, 16'h0700, 8'd1);
    begin
      int w = 0, k = 0;
      while (done !== 1'b1 && k < 2000) begin
        if (busy && !m_req) w++;
        @(negedge clk); k++;
      end
      chk("t4_wait_cycles", 128'(w), 128'(16));
    end
    chk("t4_error", 128'({done, error}), 128'({1'b1, 1'b1}));
    chk("t4_slot_kept", 128'({ram_peek(16'h0700), ram_peek(16'h0708)}),
        {64'h0000C0DE00000700, 64'h0000C0DE00000708});
    @(negedge clk);
    chk("t4_done_pulse", 128'({done, error}), 128'({1'b0, 1'b1}));
    fc_auto = 1'b1;

    // Empty batch; also clears the sticky error
    do_start(16'h0000, 16'h0000, 8'd0);
    chk("t5_done", 128'({done, busy, m_req, error}), 128'({1'b1, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    chk("t5_after", 128'({done, busy, m_req}), 128'(0));

    // Reset while waiting on the second job's interrupt, then rerun from job 0
    push(1'b1, 16'h7018, 64'd1, 8'd0);
    push_job(16'h0200, 16'h0800, 8'd0, 64'd0, 64'd0, 64'd1, 1'b0);
    push(1'b0, 16'h0208, 64'h0, 8'd1);
    push(1'b0, 16'h0208, 64'h0, 8'd1);
    push(1'b1, 16'h7020, 64'd1, 8'd1);
    push(1'b1, 16'h7000, 64'd1, 8'd1);
    do_start(16'h0200, 16'h0800, 8'd2);
    begin
      int k = 0;
      while (!(busy && !m_req && job_idx == 8'd1) && k < 2000) begin @(negedge clk); k++; end
      chk("t6_reach_wait", 128'({busy, m_req, job_idx}), 128'({1'b1, 1'b0, 8'd1}));
    end
    #2 reset = 1'b1;
    #1 chk("t6_reset_out", 128'({m_req, m_wr, m_addr, m_dout, busy, done, error, job_idx}), 128'(0));
    chk("t6_sb_empty", 128'(q.size()), 128'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    push(1'b1, 16'h7018, 64'd1, 8'd0);
    push_job(16'h0200, 16'h0800, 8'd0, 64'd0, 64'd0, 64'd1, 1'b0);
    do_start(16'h0200, 16'h0800, 8'd1);
    chk("t6_restart_job", 128'({busy, job_idx}), 128'({1'b1, 8'd0}));
    wait_done("t6");
    chk("t6_ram", 128'(ram_peek(16'h0808)), 128'(1));

    repeat (5) @(negedge clk);
    chk("sb_drained", 128'(q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
